// File: rtl/i8085_pkg.sv
// Shared types and constants for the minimal 8085-style system.
package i8085_pkg;

    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned DW        = 8;

    // Status codes as driven on S1,S0
    localparam logic [1:0] ST_HALT  = 2'b00;
    localparam logic [1:0] ST_WRITE = 2'b01;
    localparam logic [1:0] ST_READ  = 2'b10;
    localparam logic [1:0] ST_FETCH = 2'b11;

    typedef enum logic [1:0] {T1 = 2'd0, T2 = 2'd1, T3 = 2'd2, T4 = 2'd3} tstate_e;

    // Cycle type encoding equals its S1S0 status code
    typedef enum logic [1:0] {
        CYC_HALT  = ST_HALT,
        CYC_WRITE = ST_WRITE,
        CYC_READ  = ST_READ,
        CYC_FETCH = ST_FETCH
    } cycle_e;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_MVI = 8'h3E;
    localparam logic [7:0] OP_MOV = 8'h47;
    localparam logic [7:0] OP_ADD = 8'h80;
    localparam logic [7:0] OP_INR = 8'h3C;
    localparam logic [7:0] OP_STA = 8'h32;
    localparam logic [7:0] OP_JMP = 8'hC3;
    localparam logic [7:0] OP_HLT = 8'h76;

    // Reset-time memory image
    function automatic logic [DW-1:0] prog_init(input logic [7:0] addr);
        case (addr)
            8'h00:   prog_init = OP_MVI;
            8'h01:   prog_init = 8'h05;
            8'h02:   prog_init = OP_MOV;
            8'h03:   prog_init = OP_ADD;
            8'h04:   prog_init = OP_STA;
            8'h05:   prog_init = 8'hF0;
            8'h06:   prog_init = OP_INR;
            8'h07:   prog_init = OP_HLT;
            default: prog_init = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/i8085_core.sv
// CPU core: T-state sequencer, machine-cycle control, decoder and register file.
module i8085_core
    import i8085_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  bus_data,
    output logic [1:0]  tstate,
    output logic [1:0]  cycle,
    output logic [7:0]  addr,
    output logic [7:0]  acc
);

    tstate_e    t, t_nxt;
    cycle_e     cyc, cyc_nxt;
    logic [7:0] addr_q, addr_nxt;
    logic [7:0] pc, pc_nxt;
    logic [7:0] a, a_nxt;
    logic [7:0] b, b_nxt;
    logic [7:0] ir, ir_nxt;
    logic [7:0] data_in, data_in_nxt;
    logic       flag_z, flag_z_nxt;
    logic       flag_s, flag_s_nxt;
    logic       flag_cy, flag_cy_nxt;
    logic [8:0] sum;
    logic [7:0] inc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            t       <= T1;
            cyc     <= CYC_FETCH;
            addr_q  <= 8'h00;
            pc      <= 8'h00;
            a       <= 8'h00;
            b       <= 8'h00;
            ir      <= 8'h00;
            data_in <= 8'h00;
            flag_z  <= 1'b0;
            flag_s  <= 1'b0;
            flag_cy <= 1'b0;
        end else begin
            t       <= t_nxt;
            cyc     <= cyc_nxt;
            addr_q  <= addr_nxt;
            pc      <= pc_nxt;
            a       <= a_nxt;
            b       <= b_nxt;
            ir      <= ir_nxt;
            data_in <= data_in_nxt;
            flag_z  <= flag_z_nxt;
            flag_s  <= flag_s_nxt;
            flag_cy <= flag_cy_nxt;
        end
    end

    // Sequencer: data latched at end of T3, instruction executes at end of T4
    always_comb begin
        t_nxt       = t;
        cyc_nxt     = cyc;
        addr_nxt    = addr_q;
        pc_nxt      = pc;
        a_nxt       = a;
        b_nxt       = b;
        ir_nxt      = ir;
        data_in_nxt = data_in;
        flag_z_nxt  = flag_z;
        flag_s_nxt  = flag_s;
        flag_cy_nxt = flag_cy;
        sum         = 9'({1'b0, a}) + 9'({1'b0, b});
        inc         = a + 8'd1;

        unique case (t)
            T1: if (cyc != CYC_HALT) t_nxt = T2;
            T2: t_nxt = T3;
            T3: begin
                t_nxt = T4;
                if (cyc == CYC_FETCH || cyc == CYC_READ) data_in_nxt = bus_data;
            end
            T4: begin
                t_nxt   = T1;
                cyc_nxt = CYC_FETCH;
                unique case (cyc)
                    CYC_FETCH: begin
                        ir_nxt   = data_in;
                        pc_nxt   = pc + 8'd1;
                        addr_nxt = pc + 8'd1;
                        case (data_in)
                            OP_MVI, OP_STA, OP_JMP: cyc_nxt = CYC_READ;
                            OP_MOV: b_nxt = a;
                            OP_ADD: begin
                                a_nxt       = sum[7:0];
                                flag_cy_nxt = sum[8];
                                flag_z_nxt  = (sum[7:0] == 8'h00);
                                flag_s_nxt  = sum[7];
                            end
                            OP_INR: begin
                                a_nxt      = inc;
                                flag_z_nxt = (inc == 8'h00);
                                flag_s_nxt = inc[7];
                            end
                            OP_HLT: cyc_nxt = CYC_HALT;
                            default: ;
                        endcase
                    end
                    CYC_READ: begin
                        pc_nxt   = pc + 8'd1;
                        addr_nxt = pc + 8'd1;
                        case (ir)
                            OP_MVI: a_nxt = data_in;
                            OP_STA: begin
                                cyc_nxt  = CYC_WRITE;
                                addr_nxt = data_in;
                            end
                            OP_JMP: begin
                                pc_nxt   = data_in;
                                addr_nxt = data_in;
                            end
                            default: ;
                        endcase
                    end
                    CYC_WRITE: addr_nxt = pc;
                    default: cyc_nxt = cyc;
                endcase
            end
            default: t_nxt = T1;
        endcase
    end

    assign tstate = t;
    assign cycle  = cyc;
    assign addr   = addr_q;
    assign acc    = a;

endmodule

// File: rtl/i8085_system.sv
// Minimal 8085-style system: core plus 256x8 memory with observable bus status.
module i8085_system
    import i8085_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        S0,
    output logic        S1,
    output logic        IOMn,
    output logic        RDn,
    output logic        WRn,
    output logic        ALE,
    output logic [7:0]  ADD,
    output logic [7:0]  DATA,
    output logic [1:0]  state
);

    logic [DW-1:0] mem [MEM_DEPTH];
    logic [1:0]    t_s;
    logic [1:0]    cyc_s;
    logic [7:0]    acc;
    logic          strobe;
    logic          is_write;

    i8085_core U1 (
        .clk      (clk),
        .rst      (rst),
        .bus_data (DATA),
        .tstate   (t_s),
        .cycle    (cyc_s),
        .addr     (ADD),
        .acc      (acc)
    );

    // Moore bus decode from the core's registered T-state and cycle type
    assign strobe   = (t_s == T2) || (t_s == T3);
    assign is_write = (cyc_s == CYC_WRITE);
    assign S1       = cyc_s[1];
    assign S0       = cyc_s[0];
    assign IOMn     = 1'b0;
    assign ALE      = (t_s == T1) && (cyc_s != CYC_HALT);
    assign RDn      = !(strobe && cyc_s[1]);
    assign WRn      = !(strobe && is_write);
    assign DATA     = is_write ? acc : mem[ADD];
    assign state    = t_s;

    // Image reload on reset; write commits on the edge closing T3
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[8'(i)] <= prog_init(8'(i));
        end else if (is_write && t_s == T3) begin
            mem[ADD] <= DATA;
        end
    end

endmodule

// File: tb/tb_i8085_system.sv
// Scoreboard bench for i8085_system: instruction-level model predicts the bus trace.
module tb_i8085_system;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       S0, S1, IOMn, RDn, WRn, ALE;
    logic [7:0] ADD, DATA;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0] st;
        logic [1:0] s;
        logic       ale;
        logic       rd;
        logic       wr;
        logic       chk_add;
        logic       chk_data;
        logic [7:0] add;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    i8085_system dut (
        .clk   (clk),
        .rst   (rst),
        .S0    (S0),
        .S1    (S1),
        .IOMn  (IOMn),
        .RDn   (RDn),
        .WRn   (WRn),
        .ALE   (ALE),
        .ADD   (ADD),
        .DATA  (DATA),
        .state (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic push_cycle(input logic [1:0] s, input logic [7:0] addr, input logic [7:0] data);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.st       = 2'(k);
            e.s        = s;
            e.ale      = (k == 0);
            e.rd       = !((k == 1 || k == 2) && s[1]);
            e.wr       = !((k == 1 || k == 2) && s == 2'b01);
            e.chk_add  = 1'b1;
            e.chk_data = (k == 1 || k == 2);
            e.add      = addr;
            e.data     = data;
            sb.push_back(e);
        end
    endtask

    task automatic push_halt(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.st = 2'd0; e.s = 2'b00; e.ale = 1'b0; e.rd = 1'b1; e.wr = 1'b1;
            e.chk_add = 1'b0; e.chk_data = 1'b0; e.add = 8'h00; e.data = 8'h00;
            sb.push_back(e);
        end
    endtask

    // Instruction-level reference: emits one expected machine cycle per bus cycle
    task automatic gen_trace();
        logic [7:0] m [256];
        logic [7:0] prog [8];
        logic [7:0] pc, a, b, op, opd;
        bit         halted;
        int         n;
        prog = '{8'h3E, 8'h05, 8'h47, 8'h80, 8'h32, 8'hF0, 8'h3C, 8'h76};
        for (int i = 0; i < 256; i++) m[i] = (i < 8) ? prog[i] : 8'h00;
        pc = 8'h00; a = 8'h00; b = 8'h00; halted = 0; n = 0;
        while (!halted && n < 50) begin
            n++;
            op = m[pc];
            push_cycle(2'b11, pc, op);
            pc = pc + 8'd1;
            case (op)
                8'h3E: begin opd = m[pc]; push_cycle(2'b10, pc, opd); pc = pc + 8'd1; a = opd; end
                8'h47: b = a;
                8'h80: a = a + b;
                8'h3C: a = a + 8'd1;
                8'h32: begin
                    opd = m[pc]; push_cycle(2'b10, pc, opd); pc = pc + 8'd1;
                    push_cycle(2'b01, opd, a); m[opd] = a;
                end
                8'hC3: begin opd = m[pc]; push_cycle(2'b10, pc, opd); pc = opd; end
                8'h76: halted = 1;
                default: ;
            endcase
        end
        push_halt(20);
    endtask

    initial begin
        exp_t e;
        int   step;

        // Reset held for three clocks
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s1s0", 8'({S1, S0}), 8'h03);
        check("rst_rdn",  8'(RDn), 8'h01);
        check("rst_wrn",  8'(WRn), 8'h01);
        check("rst_ale",  8'(ALE), 8'h01);
        check("rst_iomn", 8'(IOMn), 8'h00);
        check("rst_add",  ADD, 8'h00);
        check("rst_state", 8'(state), 8'h00);

        gen_trace();
        rst  = 1'b1;
        step = 0;
        while (sb.size() > 0 && step < 200) begin
            e = sb.pop_front();
            check($sformatf("state@%0d", step), 8'(state), 8'(e.st));
            check($sformatf("s1s0@%0d", step), 8'({S1, S0}), 8'(e.s));
            check($sformatf("ale@%0d", step), 8'(ALE), 8'(e.ale));
            check($sformatf("rdn@%0d", step), 8'(RDn), 8'(e.rd));
            check($sformatf("wrn@%0d", step), 8'(WRn), 8'(e.wr));
            if (e.chk_add)  check($sformatf("add@%0d", step), ADD, e.add);
            if (e.chk_data) check($sformatf("data@%0d", step), DATA, e.data);
            if (step == 3)  check("data_in_first", dut.U1.data_in, 8'h3E);
            if (step == 16) begin
                check("a_after_add", dut.U1.a, 8'h0A);
                check("b_after_mov", dut.U1.b, 8'h05);
                check("z_after_add", 8'(dut.U1.flag_z), 8'h00);
                check("cy_after_add", 8'(dut.U1.flag_cy), 8'h00);
            end
            if (step == 28) check("mem_f0_written", dut.mem[8'hF0], 8'h0A);
            @(posedge clk);
            @(negedge clk);
            step++;
        end
        check("trace_drained", 8'(sb.size() == 0), 8'h01);
        check("a_after_inr", dut.U1.a, 8'h0B);

        // Reset during the STA write's T2 must suppress the write
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("abort_state", 8'(state), 8'h01);
        check("abort_s1s0", 8'({S1, S0}), 8'h01);
        check("abort_wrn", 8'(WRn), 8'h00);
        check("abort_add", ADD, 8'hF0);
        check("abort_data", DATA, 8'h0A);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_no_write", dut.mem[8'hF0], 8'h00);
        check("abort_add0", ADD, 8'h00);
        check("abort_t1", 8'(state), 8'h00);
        check("abort_fetch", 8'({S1, S0}), 8'h03);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("refetch_data_in", dut.U1.data_in, 8'h3E);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
